// File: rtl/reflet_int_ctrl.sv
// reflet_int_ctrl: a 4-source interrupt controller for the reflet CPU bus.
//
// Each raw irq_in line is synchronized through two flops (s1, s2). A third
// flop (s3) keeps the previous synchronized value so that rising edges can
// be detected. Detected requests latch into PENDING. ext_int presents
// PENDING & MASK to the CPU.
//
// Register window, at offsets from base_addr:
//   0 PENDING  read; writing 1 to a bit clears it
//   1 MASK     read/write, 1 = interrupt enabled
//   2 MODE     read/write, per bit: 0 = rising edge, 1 = level
//   3 STATUS   read-only view of the synchronized inputs (s2)
//
// Ports:
//   clk       sole clock; all state changes on its rising edge
//   reset     synchronous, active-high
//   irq_in    raw interrupt sources, asynchronous to clk
//   addr      CPU bus address, wordsize bits
//   data_in   CPU write data, wordsize bits
//   write_en  CPU write strobe
//   data_out  registered read data, one cycle of latency
//   ext_int   interrupt requests to the CPU
module reflet_int_ctrl #(
    parameter int                  wordsize  = 8,
    parameter logic [wordsize-1:0] base_addr = 8'hF0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          irq_in,
    input  logic [wordsize-1:0] addr,
    input  logic [wordsize-1:0] data_in,
    input  logic                write_en,
    output logic [wordsize-1:0] data_out,
    output logic [3:0]          ext_int
);

    logic [3:0]          s1_q, s1_d;
    logic [3:0]          s2_q, s2_d;
    logic [3:0]          s3_q, s3_d;
    logic [3:0]          pending_q, pending_d;
    logic [3:0]          mask_q, mask_d;
    logic [3:0]          mode_q, mode_d;
    logic [wordsize-1:0] data_out_q, data_out_d;

    logic [wordsize-1:0] offset;
    logic                in_win;
    logic [3:0]          set_vec;
    logic [3:0]          clr_vec;
    logic [3:0]          rd_nib;

    // Only the low nibble of the write data is stored.
    logic unused_data_in;
    assign unused_data_in = ^data_in[wordsize-1:4];

    always_comb begin
        // A subtraction decodes the window. Addresses below base_addr wrap
        // around to a large offset, so they fall outside the window, because
        // base_addr leaves room for all four registers below 2^wordsize.
        offset = addr - base_addr;
        in_win = (offset[wordsize-1:2] == '0);

        s1_d = irq_in;
        s2_d = s1_q;
        s3_d = s2_q;

        // Level mode sets the bit whenever the synchronized input is high.
        // Edge mode sets it only on a 0->1 transition of the synchronized input.
        set_vec = (mode_q & s2_q) | (~mode_q & s2_q & ~s3_q);

        clr_vec = '0;
        if (write_en && in_win && offset[1:0] == 2'd0) begin
            clr_vec = data_in[3:0];
        end

        // If a bit is set and cleared at the same edge, the set takes priority.
        pending_d = (pending_q & ~clr_vec) | set_vec;

        mask_d = mask_q;
        mode_d = mode_q;
        if (write_en && in_win && offset[1:0] == 2'd1) begin
            mask_d = data_in[3:0];
        end
        if (write_en && in_win && offset[1:0] == 2'd2) begin
            mode_d = data_in[3:0];
        end

        // Reads use the values from before the current edge, so a read and a
        // write to the same register in one cycle return the old contents.
        case (offset[1:0])
            2'd0:    rd_nib = pending_q;
            2'd1:    rd_nib = mask_q;
            2'd2:    rd_nib = mode_q;
            default: rd_nib = s2_q;
        endcase

        data_out_d = '0;
        if (in_win) begin
            data_out_d[3:0] = rd_nib;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q       <= '0;
            s2_q       <= '0;
            s3_q       <= '0;
            pending_q  <= '0;
            mask_q     <= 4'b1111;
            mode_q     <= '0;
            data_out_q <= '0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            mode_q     <= mode_d;
            data_out_q <= data_out_d;
        end
    end

    assign ext_int  = pending_q & mask_q;
    assign data_out = data_out_q;

endmodule

// File: tb/tb_reflet_int_ctrl.sv
// Testbench for reflet_int_ctrl. A reference model tracks the register
// contents and the history of sampled irq_in values. Directed scenarios
// exercise the documented behaviours, then randomized traffic follows.
module tb_reflet_int_ctrl;
    localparam int        W    = 8;
    localparam logic [7:0] BASE = 8'hF0;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   irq_in;
    logic [W-1:0] addr;
    logic [W-1:0] data_in;
    logic         write_en;
    logic [W-1:0] data_out;
    logic [3:0]   ext_int;

    reflet_int_ctrl #(.wordsize(W), .base_addr(BASE)) dut (
        .clk      (clk),
        .reset    (reset),
        .irq_in   (irq_in),
        .addr     (addr),
        .data_in  (data_in),
        .write_en (write_en),
        .data_out (data_out),
        .ext_int  (ext_int)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state. irq_hist[k] holds the irq_in value sampled k+1 edges ago.
    logic [3:0] m_pend, m_mask, m_mode;
    logic [3:0] irq_hist [3];
    logic [7:0] m_dout;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input logic rst, input logic [3:0] irq, input logic [7:0] a,
                              input logic [7:0] d, input logic we);
        logic [3:0] seen, seen_prev, set_bits, clr_bits;
        int off;
        if (rst) begin
            m_pend = 4'h0; m_mask = 4'hF; m_mode = 4'h0; m_dout = 8'h00;
            for (int k = 0; k < 3; k++) irq_hist[k] = 4'h0;
        end else begin
            // The request logic acts on the input value sampled two edges
            // earlier, because of the synchronizer delay, and compares it
            // with the value sampled three edges earlier.
            seen      = irq_hist[1];
            seen_prev = irq_hist[2];
            off = int'(a) - int'(BASE);
            if (off >= 0 && off <= 3) begin
                case (off)
                    0: m_dout = {4'h0, m_pend};
                    1: m_dout = {4'h0, m_mask};
                    2: m_dout = {4'h0, m_mode};
                    default: m_dout = {4'h0, seen};
                endcase
            end else begin
                m_dout = 8'h00;
            end
            set_bits = 4'h0;
            for (int b = 0; b < 4; b++) begin
                if (m_mode[b]) set_bits[b] = seen[b];
                else           set_bits[b] = seen[b] && !seen_prev[b];
            end
            clr_bits = (we && off == 0) ? d[3:0] : 4'h0;
            m_pend = (m_pend & ~clr_bits) | set_bits;
            if (we && off == 1) m_mask = d[3:0];
            if (we && off == 2) m_mode = d[3:0];
            irq_hist[2] = irq_hist[1];
            irq_hist[1] = irq_hist[0];
            irq_hist[0] = irq;
        end
    endtask

    // Apply one cycle of inputs, advance past the edge, and compare with the model.
    task automatic cycle(input logic rst, input logic [3:0] irq, input logic [7:0] a,
                         input logic [7:0] d, input logic we);
        reset = rst; irq_in = irq; addr = a; data_in = d; write_en = we;
        @(posedge clk);
        model_edge(rst, irq, a, d, we);
        #1;
        check("ext_int", {28'd0, ext_int}, {28'd0, m_pend & m_mask});
        check("data_out", {24'd0, data_out}, {24'd0, m_dout});
    endtask

    task automatic idle(input logic [3:0] irq, input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, irq, 8'h00, 8'h00, 1'b0);
    endtask

    initial begin
        logic [7:0] a;
        logic [3:0] irq;
        int pick;

        cycle(1'b1, 4'h0, 8'h00, 8'h00, 1'b0);
        check("rst_ext", {28'd0, ext_int}, 32'h0);
        check("rst_dout", {24'd0, data_out}, 32'h0);
        cycle(1'b0, 4'h0, BASE + 8'd1, 8'h00, 1'b0);
        check("rst_mask", {24'd0, data_out}, 32'h0F);

        // irq0 held for five cycles; the request appears after the third edge and stays latched.
        cycle(1'b1, 4'h0, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 4'h1, 8'h00, 8'h00, 1'b0);
            check("edge_lat", {28'd0, ext_int}, (i >= 2) ? 32'h1 : 32'h0);
        end
        idle(4'h0, 3);
        check("edge_hold", {28'd0, ext_int}, 32'h1);

        // Write-1-to-clear
        cycle(1'b0, 4'h0, BASE, 8'h01, 1'b1);
        check("clr_ext", {28'd0, ext_int}, 32'h0);
        cycle(1'b0, 4'h0, BASE, 8'h00, 1'b0);
        check("clr_read", {24'd0, data_out}, 32'h00);

        // A masked source still latches; unmasking it raises the interrupt.
        cycle(1'b0, 4'h0, BASE + 8'd1, 8'h0E, 1'b1);
        cycle(1'b0, 4'h1, 8'h00, 8'h00, 1'b0);
        idle(4'h0, 4);
        check("mask_ext", {28'd0, ext_int}, 32'h0);
        cycle(1'b0, 4'h0, BASE, 8'h00, 1'b0);
        check("mask_pend", {24'd0, data_out}, 32'h01);
        cycle(1'b0, 4'h0, BASE + 8'd1, 8'h0F, 1'b1);
        check("unmask_ext", {28'd0, ext_int}, 32'h1);

        // Level mode: a held input re-sets PENDING despite a clear.
        cycle(1'b0, 4'h0, BASE, 8'h0F, 1'b1);
        cycle(1'b0, 4'h0, BASE + 8'd2, 8'h04, 1'b1);
        idle(4'h4, 4);
        cycle(1'b0, 4'h4, BASE, 8'h04, 1'b1);
        check("lvl_hold", {31'd0, ext_int[2]}, 32'h1);
        idle(4'h0, 3);
        cycle(1'b0, 4'h0, BASE, 8'h04, 1'b1);
        cycle(1'b0, 4'h0, BASE, 8'h00, 1'b0);
        check("lvl_clr", {31'd0, data_out[2]}, 32'h0);

        // An edge that coincides with a clear: the set takes priority.
        cycle(1'b0, 4'h0, BASE + 8'd2, 8'h00, 1'b1);
        cycle(1'b0, 4'h0, BASE, 8'h0F, 1'b1);
        idle(4'h0, 2);
        cycle(1'b0, 4'h8, 8'h00, 8'h00, 1'b0);
        cycle(1'b0, 4'h8, 8'h00, 8'h00, 1'b0);
        cycle(1'b0, 4'h8, BASE, 8'h08, 1'b1);
        check("set_wins", {31'd0, ext_int[3]}, 32'h1);

        // STATUS read, and reads outside the window
        idle(4'hA, 3);
        cycle(1'b0, 4'hA, BASE + 8'd3, 8'h00, 1'b0);
        check("status", {24'd0, data_out}, 32'h0A);
        cycle(1'b0, 4'hA, 8'h10, 8'h00, 1'b0);
        check("oob_read", {24'd0, data_out}, 32'h00);
        cycle(1'b0, 4'hA, BASE + 8'd3, 8'h0F, 1'b1);
        cycle(1'b0, 4'hA, BASE + 8'd4, 8'h0F, 1'b1);
        cycle(1'b0, 4'hA, BASE - 8'd1, 8'h00, 1'b0);
        check("below_read", {24'd0, data_out}, 32'h00);

        // An input held high across reset release produces exactly one edge request.
        cycle(1'b1, 4'h2, 8'h00, 8'h00, 1'b0);
        cycle(1'b1, 4'h2, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 4'h2, 8'h00, 8'h00, 1'b0);
            check("rel_edge", {28'd0, ext_int}, (i >= 2) ? 32'h2 : 32'h0);
        end
        cycle(1'b0, 4'h2, BASE, 8'h02, 1'b1);
        idle(4'h2, 4);
        check("rel_once", {28'd0, ext_int}, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            pick = $urandom_range(0, 9);
            case (pick)
                0, 1, 2: a = BASE;
                3:       a = BASE + 8'd1;
                4:       a = BASE + 8'd2;
                5:       a = BASE + 8'd3;
                6:       a = BASE + 8'd4;
                7:       a = BASE - 8'd1;
                default: a = 8'($urandom);
            endcase
            irq = ($urandom_range(0, 3) == 0) ? 4'($urandom) : irq_in;
            cycle(($urandom_range(0, 60) == 0), irq, a, 8'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/reflet_int_ctrl.md
REFLET_INT_CTRL -- requirements
Module: reflet_int_ctrl

Interface
REQ-001 SHALL have parameter wordsize, default 8, bus data/address width; legal values >= 4.
REQ-002 SHALL have parameter base_addr, default 8'hF0, address of register 0; registers occupy base_addr..base_addr+3.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port irq_in  input  4  raw interrupt sources, asynchronous to clk.
REQ-006 SHALL have port addr  input  wordsize  CPU bus address.
REQ-007 SHALL have port data_in  input  wordsize  CPU write data (CPU data_out).
REQ-008 SHALL have port write_en  input  1  CPU write strobe.
REQ-009 SHALL have port data_out  output  wordsize  read data to the CPU data_in mux.
REQ-010 SHALL have port ext_int  output  4  interrupt requests, connects directly to reflet_cpu ext_int.

Function
REQ-011 SHALL pass each irq_in bit through a 2-flop synchronizer (s1, s2) followed by a history flop s3.
REQ-012 Register map (offset from base_addr): 0 PENDING (read; write-1-to-clear), 1 MASK (rw, 1 = enabled), 2 MODE (rw, per bit 0 = rising edge, 1 = level), 3 STATUS (read-only, s2 value); writes to 3 ignored.
REQ-013 Only bits [3:0] of any register SHALL be stored; read bits [wordsize-1:4] SHALL be 0.
REQ-014 Edge mode: PENDING[i] SHALL set at the edge where s2[i]=1 and s3[i]=0; ext_int[i] high after the 3rd rising clk edge sampling irq_in[i] high.
REQ-015 Level mode: PENDING[i] SHALL be loaded with 1 every cycle s2[i]=1; otherwise holds.
REQ-016 Any irq_in pulse high for >= 1 full clk period SHALL set PENDING; shorter pulses may be lost.
REQ-017 Write to offset 0 with write_en=1 SHALL clear every PENDING bit whose data_in bit is 1, at that edge.
REQ-018 Simultaneous set condition and clear on the same bit SHALL leave the bit set (set wins).
REQ-019 Writes to offsets 1 and 2 SHALL update MASK/MODE at the write edge; addresses outside the window SHALL be ignored.
REQ-020 ext_int SHALL equal PENDING & MASK, driven from registers only (no combinational path from irq_in, addr or data_in).
REQ-021 Masked bits SHALL still latch into PENDING; setting the MASK bit with PENDING set SHALL raise ext_int the cycle after the write edge.
REQ-022 Changing MODE SHALL not alter PENDING directly.
REQ-023 data_out SHALL be registered: value at edge k reflects addr sampled at edge k, visible in cycle k+1 (one-cycle read latency, matching the ROM).
REQ-024 data_out SHALL be 0 when the sampled addr is outside base_addr..base_addr+3.
REQ-025 A read and a write to the same register in one cycle SHALL return the pre-write value.
REQ-026 Address comparison SHALL use the full wordsize bits; wrap past 2^wordsize-1 is not supported (base_addr <= 2^wordsize-4).

Reset
REQ-027 While reset=1 at a rising edge: s1, s2, s3, PENDING, MODE = 0; MASK = 4'b1111; data_out = 0; ext_int = 0.
REQ-028 Reset asserted mid-operation SHALL discard pending requests and any in-flight synchronizer state in that cycle.
REQ-029 An irq_in line held high across reset release SHALL, in edge mode, produce exactly one PENDING set, 3 edges after the first non-reset edge.
REQ-030 No write or set SHALL take effect at an edge where reset=1.

Verification
REQ-031 Reset, then irq_in=4'b0001 for 5 cycles -> ext_int=4'b0001 after 3rd sampling edge, stays set after irq_in drops.
REQ-032 Pending bit 0 set, write 8'h01 to base_addr -> ext_int=4'b0000 next cycle; read base_addr returns 8'h00.
REQ-033 MASK=4'b1110, pulse irq_in[0] -> ext_int=0, read base_addr returns 8'h01; write MASK=8'h0F -> ext_int=4'b0001 next cycle.
REQ-034 MODE=4'b0100, hold irq_in[2] high, write 8'h04 to base_addr -> PENDING[2] stays 1; drop irq_in[2], clear again -> 0.
REQ-035 Edge on irq_in[3] coinciding with a clear write of 8'h08 -> PENDING[3]=1 after the edge.
REQ-036 Read base_addr+3 with irq_in=4'b1010 stable -> data_out=8'h0A one cycle after addr; read 8'h10 -> data_out=8'h00.
